// File: rtl/debug_pkg.sv
// Shared definitions for the debug step controller: UART command codes
// and the controller state encoding (reported on state_out).
// DEBUG_CYCLE_COUNT_EN adds the SEND_CNT state for the cycle-count byte.
package debug_pkg;

  localparam logic [7:0] CMD_CONT  = 8'h63;  // 'c' continuous run
  localparam logic [7:0] CMD_STEP  = 8'h73;  // 's' enter step mode
  localparam logic [7:0] CMD_NEXT  = 8'h6E;  // 'n' single step
  localparam logic [7:0] CMD_RESET = 8'h72;  // 'r' processor soft reset

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RUN        = 3'd1,
    STEP_WAIT  = 3'd2,
    STEP_PULSE = 3'd3,
    SEND_PC    = 3'd4,
`ifdef DEBUG_CYCLE_COUNT_EN
    SEND_CNT   = 3'd5,
`endif
    WAIT_TX    = 3'd6
  } state_t;

endpackage

// File: rtl/debug_cmd_decoder.sv
// Turns a strobed UART byte into one-hot command pulses; any byte that is
// not a known command code produces no pulse at all.
module debug_cmd_decoder
  import debug_pkg::*;
(
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_cont,
  output logic       cmd_step,
  output logic       cmd_next,
  output logic       cmd_reset
);

  // Match the qualified byte against each command code in the same cycle
  always_comb begin
    cmd_cont  = rx_valid && (rx_data == CMD_CONT);
    cmd_step  = rx_valid && (rx_data == CMD_STEP);
    cmd_next  = rx_valid && (rx_data == CMD_NEXT);
    cmd_reset = rx_valid && (rx_data == CMD_RESET);
  end

endmodule

// File: rtl/debug_step_controller.sv
// UART-driven run/step controller for a small processor. Commands start a
// free run, enter step mode, single-step or soft-reset the core; after a
// run halts or a step completes the current PC is reported over the UART.
// Define DEBUG_CYCLE_COUNT_EN to also count enabled cycles and append the
// low byte of that count to every report.
module debug_step_controller
  import debug_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  input  logic [PC_W-1:0] pc_value,
  input  logic            halt_detected,
  input  logic            tx_busy,
  output logic            enable_debug,
  output logic            reset_debug,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  output logic [2:0]      state_out
);

  if (PC_W < 1 || CNT_W < 1) begin : g_param_check
    $error("debug_step_controller: PC_W and CNT_W must be at least 1");
  end

  logic   cmd_cont, cmd_step, cmd_next, cmd_reset;
  state_t state;
  logic   from_step;
  logic   busy_seen;

  debug_cmd_decoder u_decoder (
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_cont  (cmd_cont),
    .cmd_step  (cmd_step),
    .cmd_next  (cmd_next),
    .cmd_reset (cmd_reset)
  );

  assign state_out = state;

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic             report_last;

  // Count every cycle the core is allowed to advance; a soft reset clears it
  always_ff @(posedge clk) begin
    if (reset || reset_debug) begin
      cycle_cnt <= '0;
    end else if (enable_debug) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end
`endif

  // Main controller: all outputs are registered so enable/reset never glitch
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      enable_debug <= 1'b0;
      reset_debug  <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      from_step    <= 1'b0;
      busy_seen    <= 1'b0;
`ifdef DEBUG_CYCLE_COUNT_EN
      report_last  <= 1'b0;
`endif
    end else begin
      reset_debug <= 1'b0;
      tx_start    <= 1'b0;
      case (state)
        IDLE: begin
          enable_debug <= 1'b0;
          if (cmd_cont) begin
            state        <= RUN;
            enable_debug <= 1'b1;
            from_step    <= 1'b0;
          end else if (cmd_step) begin
            state     <= STEP_WAIT;
            from_step <= 1'b1;
          end else if (cmd_reset) begin
            reset_debug <= 1'b1;
          end
        end
        RUN: begin
          if (cmd_reset) begin
            enable_debug <= 1'b0;
            reset_debug  <= 1'b1;
            state        <= IDLE;
          end else if (halt_detected) begin
            enable_debug <= 1'b0;
            state        <= SEND_PC;
          end else begin
            enable_debug <= 1'b1;
          end
        end
        STEP_WAIT: begin
          enable_debug <= 1'b0;
          from_step    <= 1'b1;
          if (cmd_next) begin
            enable_debug <= 1'b1;
            state        <= STEP_PULSE;
          end else if (cmd_reset) begin
            reset_debug <= 1'b1;
          end
        end
        STEP_PULSE: begin
          enable_debug <= 1'b0;
          if (halt_detected) from_step <= 1'b0;
          state <= SEND_PC;
        end
        SEND_PC: begin
          if (halt_detected) from_step <= 1'b0;
          if (!tx_busy) begin
            tx_data   <= 8'(pc_value);
            tx_start  <= 1'b1;
            busy_seen <= 1'b0;
`ifdef DEBUG_CYCLE_COUNT_EN
            report_last <= 1'b0;
`endif
            state     <= WAIT_TX;
          end
        end
`ifdef DEBUG_CYCLE_COUNT_EN
        SEND_CNT: begin
          if (halt_detected) from_step <= 1'b0;
          if (!tx_busy) begin
            tx_data     <= 8'(cycle_cnt);
            tx_start    <= 1'b1;
            busy_seen   <= 1'b0;
            report_last <= 1'b1;
            state       <= WAIT_TX;
          end
        end
`endif
        WAIT_TX: begin
          if (halt_detected) from_step <= 1'b0;
          if (!busy_seen) begin
            if (tx_busy) busy_seen <= 1'b1;
          end else if (!tx_busy) begin
`ifdef DEBUG_CYCLE_COUNT_EN
            if (!report_last) state <= SEND_CNT;
            else
`endif
            if (from_step) state <= STEP_WAIT;
            else state <= IDLE;
          end
        end
        default: begin
          enable_debug <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_step_controller.sv
// Scoreboard bench for debug_step_controller: stimulus tasks push the bytes
// a report should contain, a monitor pops and compares them on tx_start.
module tb_debug_step_controller;
  import debug_pkg::*;

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int REPORT_BYTES = 2;
`else
  localparam int REPORT_BYTES = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] pc_value = 8'h00;
  logic       halt_detected = 1'b0;
  logic       tx_busy;
  logic       enable_debug, reset_debug, tx_start;
  logic [7:0] tx_data;
  logic [2:0] state_out;

  logic uart_busy = 1'b0;
  logic force_busy = 1'b0;
  assign tx_busy = uart_busy | force_busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;
  int tx_count = 0;
  int en_cycles = 0;
  int en_pulses = 0;
  int rst_cycles = 0;
  logic en_prev = 1'b0;
  int cnt_model = 0;

  always #5 clk = ~clk;

  debug_step_controller #(.PC_W(8), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .pc_value      (pc_value),
    .halt_detected (halt_detected),
    .tx_busy       (tx_busy),
    .enable_debug  (enable_debug),
    .reset_debug   (reset_debug),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .state_out     (state_out)
  );

  // UART transmitter model: busy rises after a start request, then falls
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on every tx_start, plus cycle-level invariants
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      tx_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL txByte: got 0x%02h, required no transmission", tx_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (tx_data !== sb_exp) begin
          miscompares++;
          $display("[TB] FAIL txByte: got 0x%02h, required 0x%02h", tx_data, sb_exp);
        end
      end
      if (tx_busy === 1'b1) begin
        miscompares++;
        $display("[TB] FAIL startWhileBusy: tx_start=1 with tx_busy=1, required tx_busy=0");
      end
    end
    if (enable_debug === 1'b1 && reset_debug === 1'b1) begin
      miscompares++;
      $display("[TB] FAIL enableAndReset: both 1, required at most one");
    end
    if (enable_debug === 1'b1) en_cycles++;
    if (enable_debug === 1'b1 && en_prev !== 1'b1) en_pulses++;
    if (reset_debug === 1'b1) rst_cycles++;
    en_prev = enable_debug;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  function automatic logic [7:0] junkByte();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255));
    while (b == 8'h63 || b == 8'h73 || b == 8'h6E || b == 8'h72);
    return b;
  endfunction

  // Report bytes the spec requires after `cycles` more enabled cycles
  task automatic expectReport(input int cycles);
    exp_q.push_back(pc_value);
    cnt_model = (cnt_model + cycles) % 256;
`ifdef DEBUG_CYCLE_COUNT_EN
    exp_q.push_back(8'(cnt_model));
`endif
  endtask

  task automatic waitReport(input state_t target);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && state_out == target) break;
      tick();
    end
    checkOutput("reportDrained", exp_q.size(), 0);
    checkOutput("reportEndState", int'(state_out), int'(target));
  endtask

  task automatic doRun(input int n, input logic [7:0] pc, input bit holdBusy);
    int en0, tx0;
    en0 = en_cycles;
    tx0 = tx_count;
    pc_value = pc;
    expectReport(n);
    applyStimulus(8'h63);
    repeat (n - 1) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: rx_data = 8'h63;
          1: rx_data = 8'h73;
          2: rx_data = 8'h6E;
          default: rx_data = junkByte();
        endcase
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
    end
    if (holdBusy) force_busy = 1'b1;
    halt_detected = 1'b1;
    tick();
    halt_detected = 1'b0;
    if (holdBusy) begin
      repeat (20) tick();
      checkOutput("busyHoldNoStart", tx_count - tx0, 0);
      force_busy = 1'b0;
    end
    waitReport(IDLE);
    tick();
    checkOutput("runEnableCycles", en_cycles - en0, n);
    checkOutput("runTxCount", tx_count - tx0, REPORT_BYTES);
  endtask

  task automatic doRunAbort(input int m);
    int en0, rst0, tx0;
    en0 = en_cycles; rst0 = rst_cycles; tx0 = tx_count;
    applyStimulus(8'h63);
    repeat (m - 1) tick();
    applyStimulus(8'h72);
    checkOutput("abortState", int'(state_out), int'(IDLE));
    cnt_model = 0;
    repeat (3) tick();
    checkOutput("abortEnableCycles", en_cycles - en0, m);
    checkOutput("abortResetPulse", rst_cycles - rst0, 1);
    checkOutput("abortNoTx", tx_count - tx0, 0);
  endtask

  task automatic doSoftResetIdle();
    int en0, rst0, tx0;
    en0 = en_cycles; rst0 = rst_cycles; tx0 = tx_count;
    applyStimulus(8'h72);
    cnt_model = 0;
    repeat (3) tick();
    checkOutput("idleResetPulse", rst_cycles - rst0, 1);
    checkOutput("idleResetNoEnable", en_cycles - en0, 0);
    checkOutput("idleResetNoTx", tx_count - tx0, 0);
    checkOutput("idleResetState", int'(state_out), int'(IDLE));
  endtask

  task automatic doStepSession(input int k, input bit directed);
    int en0, p0, rst0;
    applyStimulus(8'h73);
    checkOutput("stepEntry", int'(state_out), int'(STEP_WAIT));
    rst0 = rst_cycles;
    applyStimulus(8'h72);
    cnt_model = 0;
    repeat (2) tick();
    checkOutput("stepSoftReset", rst_cycles - rst0, 1);
    checkOutput("stepStays", int'(state_out), int'(STEP_WAIT));
    en0 = en_cycles;
    p0  = en_pulses;
    for (int j = 0; j < k; j++) begin
      if ($urandom_range(0, 2) == 0) applyStimulus(($urandom_range(0, 1) == 0) ? 8'h63 : 8'h73);
      pc_value = directed ? 8'(4 * (j + 1)) : 8'($urandom_range(0, 255));
      expectReport(1);
      applyStimulus(8'h6E);
      if (j == k - 1) begin
        halt_detected = 1'b1;
        tick();
        halt_detected = 1'b0;
        waitReport(IDLE);
      end else begin
        waitReport(STEP_WAIT);
      end
    end
    tick();
    checkOutput("stepEnableCycles", en_cycles - en0, k);
    checkOutput("stepEnablePulses", en_pulses - p0, k);
  endtask

  task automatic doResetMidTx(input int n, input logic [7:0] pc);
    int tx0;
    tx0 = tx_count;
    pc_value = pc;
    exp_q.push_back(pc);
    applyStimulus(8'h63);
    repeat (n - 1) tick();
    halt_detected = 1'b1;
    tick();
    halt_detected = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx_count != tx0) break;
      tick();
    end
    checkOutput("midTxStartSeen", tx_count - tx0, 1);
    checkOutput("midTxInWait", int'(state_out), int'(WAIT_TX));
    reset = 1'b1;
    tick();
    checkOutput("midTxResetState", int'(state_out), int'(IDLE));
    checkOutput("midTxResetEnable", int'(enable_debug), 0);
    checkOutput("midTxResetSoft", int'(reset_debug), 0);
    checkOutput("midTxResetStart", int'(tx_start), 0);
    checkOutput("midTxResetData", int'(tx_data), 0);
    reset = 1'b0;
    cnt_model = 0;
    repeat (20) tick();
    checkOutput("midTxNoMoreStart", tx_count - tx0, 1);
    checkOutput("midTxState", int'(state_out), int'(IDLE));
  endtask

  // Top-level sequence: directed scenarios first, then a randomized mix
  initial begin
    int sel;
    int tx0, en0;
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("resetState", int'(state_out), int'(IDLE));
    checkOutput("resetEnable", int'(enable_debug), 0);
    checkOutput("resetSoft", int'(reset_debug), 0);
    checkOutput("resetStart", int'(tx_start), 0);
    checkOutput("resetData", int'(tx_data), 0);
    reset = 1'b0;
    tick();

    doRun(10, 8'h28, 1'b0);
    doStepSession(3, 1'b1);
    doSoftResetIdle();
    doRunAbort(7);
    doRun(3, 8'($urandom_range(0, 255)), 1'b1);
    doResetMidTx(5, 8'h5A);
    doSoftResetIdle();
    doRun(260, 8'($urandom_range(0, 255)), 1'b0);

    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        doRun($urandom_range(1, 40), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end else if (sel == 1) begin
        doStepSession($urandom_range(1, 4), 1'b0);
      end else begin
        tx0 = tx_count;
        en0 = en_cycles;
        applyStimulus(($urandom_range(0, 1) == 0) ? 8'h6E : junkByte());
        repeat (2) tick();
        checkOutput("idleIgnored", int'(state_out), int'(IDLE));
        checkOutput("idleIgnoredQuiet", (tx_count - tx0) + (en_cycles - en0), 0);
      end
    end

    repeat (5) tick();
    checkOutput("scoreboardEmpty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so a stuck handshake cannot hang the run
  initial begin
    #1000000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/debug_step_controller.md
DEBUG_STEP_CONTROLLER -- requirements
Module: debug_step_controller

Interface
REQ-001 SHALL have parameter PC_W, default 8, the width of the processor program-counter value that is reported.
REQ-002 SHALL have parameter CNT_W, default 8, the width of the executed-cycle counter.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_data  input  8  command byte from the UART receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port pc_value  input  PC_W  current processor program counter.
REQ-008 SHALL have port halt_detected  input  1  HALT instruction has retired.
REQ-009 SHALL have port tx_busy  input  1  UART transmitter is sending a byte.
REQ-010 SHALL have port enable_debug  output  1  processor advance enable (PC, pipeline registers).
REQ-011 SHALL have port reset_debug  output  1  processor soft reset (PC and pipeline to 0).
REQ-012 SHALL have port tx_data  output  8  byte to transmit.
REQ-013 SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-014 SHALL have port state_out  output  3  current FSM state encoding.

Function
REQ-015 SHALL decode commands: 0x63 'c' continuous run, 0x73 's' enter step mode, 0x6E 'n' single step, 0x72 'r' soft reset; all other bytes are ignored.
REQ-016 SHALL implement FSM states IDLE, RUN, STEP_WAIT, STEP_PULSE, SEND_PC, SEND_CNT, WAIT_TX.
REQ-017 In IDLE, 'c' SHALL move to RUN, 's' to STEP_WAIT, 'r' SHALL assert reset_debug for exactly one cycle and remain in IDLE.
REQ-018 In RUN, enable_debug SHALL be 1 every cycle until halt_detected is sampled 1; then enable_debug SHALL be 0 from the next cycle and the FSM SHALL move to SEND_PC.
REQ-019 In STEP_WAIT, enable_debug SHALL be 0; 'n' SHALL move to STEP_PULSE; 'r' SHALL pulse reset_debug one cycle and stay in STEP_WAIT.
REQ-020 STEP_PULSE SHALL assert enable_debug for exactly one cycle, then move to SEND_PC.
REQ-021 SEND_PC SHALL, when tx_busy is 0, drive tx_data with pc_value zero-extended or truncated to 8 bits and pulse tx_start one cycle, then go to WAIT_TX.
REQ-022 WAIT_TX SHALL wait for tx_busy to rise and then fall before the next transmission or state; a byte SHALL never be requested while tx_busy is 1.
REQ-023 After the final report byte, the FSM SHALL return to STEP_WAIT if the report originated from a step, otherwise to IDLE.
REQ-024 Commands received in RUN, STEP_PULSE, SEND_PC, SEND_CNT and WAIT_TX SHALL be dropped, except 'r' in RUN, which SHALL pulse reset_debug, clear enable_debug and go to IDLE.
REQ-025 halt_detected in step mode SHALL cause return to IDLE after the report instead of STEP_WAIT.
REQ-026 enable_debug and reset_debug SHALL never be 1 in the same cycle.

Reset
REQ-027 reset SHALL force IDLE, enable_debug=0, reset_debug=0, tx_start=0, tx_data=0x00, cycle counter=0, in the next cycle, including mid-transmission.

Configuration
REQ-028 With DEBUG_CYCLE_COUNT_EN defined, a CNT_W-bit counter SHALL increment on every cycle with enable_debug=1, SHALL clear on reset_debug, SHALL wrap at 2^CNT_W-1 to 0, and SEND_CNT SHALL transmit its low 8 bits after the PC byte.
REQ-029 Without DEBUG_CYCLE_COUNT_EN, the counter and SEND_CNT SHALL not exist and the report SHALL be the PC byte only.

Structure
REQ-030 Command byte constants and the state encoding SHALL reside in shared package debug_pkg.
REQ-031 Command decoding SHALL be a sub-module debug_cmd_decoder producing one-hot cmd_cont/cmd_step/cmd_next/cmd_reset pulses.

Verification
REQ-032 'c' then halt_detected after 10 cycles, pc_value=0x28 -> enable_debug high 10 cycles, one tx_start with tx_data=0x28 (then 0x0A with macro).
REQ-033 's', 'n' x3, pc_value 0x04/0x08/0x0C -> exactly three one-cycle enable_debug pulses, bytes 0x04, 0x08, 0x0C sent in order.
REQ-034 'r' in IDLE -> reset_debug high exactly one cycle, enable_debug 0, no tx_start.
REQ-035 tx_busy held high 20 cycles during SEND_PC -> tx_start stays 0 until tx_busy falls, then one pulse.
REQ-036 reset asserted while in WAIT_TX -> IDLE next cycle, all outputs 0, no further tx_start.
REQ-037 With macro, CNT_W=8, 260 running cycles then halt -> count byte 0x04.
